// File: rtl/display_pkg.sv
// Shared types and constants for the stopwatch display stage.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BIN_BITS   = 10;

  // Active-low segment patterns {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/display_mux_seg7_decode.sv
// Nibble to active-low 7-segment pattern; values 10-15 render as a dash.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Plain lookup, no blanking or overflow handling here
  always_comb begin
    seg = SEG_DASH;
    unique case (nibble)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_mux.sv
// Stopwatch display: sequential binary-to-BCD conversion of the seconds
// count and a 4-digit multiplexed common-anode scan showing "SSS.d".
module display_mux
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_BITS-1:0]   cont_seg,
  input  logic [3:0]            cont_dec,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  conv_done
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  conv_state_e         state_q, state_d;
  logic [BIN_BITS-1:0] bin_q, bin_d;
  logic [11:0]         bcd_q, bcd_d;
  logic [11:0]         bcd_adj;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          dec_cap_q, dec_cap_d;
  logic                ovf_cap_q, ovf_cap_d;

  logic [3:0]          hund_q, hund_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          unit_q, unit_d;
  logic [3:0]          tenth_q, tenth_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [PW-1:0]       presc_q, presc_d;
  logic [1:0]          idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  logic [3:0]          digit_nib;
  logic [6:0]          digit_seg;

  // Conversion FSM: capture, 10 add-3/shift steps, then commit to display
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    dec_cap_d = dec_cap_q;
    ovf_cap_d = ovf_cap_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    unit_d    = unit_q;
    tenth_d   = tenth_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      IDLE: begin
        bin_d     = cont_seg;
        dec_cap_d = cont_dec;
        bcd_d     = '0;
        cnt_d     = '0;
        ovf_cap_d = (cont_seg > 10'd999);
        state_d   = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        if (cnt_q == 4'(BIN_BITS - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        unit_d  = bcd_q[3:0];
        tenth_d = dec_cap_q;
        ovf_d   = ovf_cap_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Conversion and display registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      dec_cap_q <= '0;
      ovf_cap_q <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      unit_q    <= '0;
      tenth_q   <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      dec_cap_q <= dec_cap_d;
      ovf_cap_q <= ovf_cap_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      unit_q    <= unit_d;
      tenth_q   <= tenth_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  // Digit selected by the scan index
  always_comb begin
    digit_nib = tenth_q;
    unique case (idx_q)
      2'd3:    digit_nib = hund_q;
      2'd2:    digit_nib = tens_q;
      2'd1:    digit_nib = unit_q;
      default: digit_nib = tenth_q;
    endcase
  end

  seg7_decode u_dec (
    .nibble (digit_nib),
    .seg    (digit_seg)
  );

  // Scan prescaler/index and next display outputs (overflow beats blanking)
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end

    an_d  = ~(4'b0001 << idx_q);
    dp_d  = (idx_q != 2'd1);
    seg_d = digit_seg;
    if (ovf_q && (idx_q != 2'd0)) begin
      seg_d = SEG_DASH;
    end else if (BLANK_LZ && (idx_q == 2'd3) && (hund_q == 4'd0)) begin
      seg_d = SEG_BLANK;
    end else if (BLANK_LZ && (idx_q == 2'd2) && (hund_q == 4'd0) && (tens_q == 4'd0)) begin
      seg_d = SEG_BLANK;
    end
  end

  // Scan registers and registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= '1;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign conv_done = done_q;

endmodule
